// File: rtl/key_pulse_gen.sv
// key_pulse_gen: debounces the five active-low push buttons as one 5-bit
// vector and turns each accepted press into a one-cycle key code strobe,
// with optional auto-repeat while the same code stays held.
module key_pulse_gen #(
   parameter int          DEBOUNCE_CYCLES = 250000,
   parameter bit          REPEAT_EN       = 1'b1,
   parameter int          REPEAT_DELAY    = 12500000,
   parameter int          REPEAT_RATE     = 2500000,
   parameter logic [4:0]  IDLE_CODE       = 5'h1f
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] key_raw,
   output logic [4:0] key,
   output logic [4:0] key_pulse,
   output logic       key_valid
);

   localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

   localparam logic [DW-1:0] DCNT_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FIRST  = 2'd1,
      S_REPEAT = 2'd2
   } state_t;

   logic [4:0]    sync_p0;
   logic [4:0]    sync_p1;
   logic [4:0]    cand;
   logic [DW-1:0] dcnt;
   logic [RW-1:0] rcnt;
   state_t        state;
   logic          accept;

   // Stable candidate that has aged fully and differs from the current key.
   assign accept = (sync_p1 == cand) && (dcnt == DCNT_LAST) && (cand != key);

   // Two-flop synchronizer bringing the asynchronous buttons into clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0 <= IDLE_CODE;
         sync_p1 <= IDLE_CODE;
      end else begin
         sync_p0 <= key_raw;
         sync_p1 <= sync_p0;
      end
   end

   // Debounce: any change restarts the age count; a fully aged new value
   // becomes the stable key. The count saturates so a held value stays put.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cand <= IDLE_CODE;
         dcnt <= '0;
         key  <= IDLE_CODE;
      end else if (sync_p1 != cand) begin
         cand <= sync_p1;
         dcnt <= '0;
      end else begin
         if (accept) begin
            key <= cand;
         end
         if (dcnt != DCNT_LAST) begin
            dcnt <= dcnt + 1'b1;
         end
      end
   end

   // Press / repeat strobe FSM. Acceptance always wins over a repeat because
   // it restarts rcnt on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         rcnt      <= '0;
         key_pulse <= IDLE_CODE;
         key_valid <= 1'b0;
      end else begin
         key_pulse <= IDLE_CODE;
         key_valid <= 1'b0;
         if (accept) begin
            rcnt <= '0;
            if (cand == IDLE_CODE) begin
               state <= S_IDLE;
            end else begin
               state     <= S_FIRST;
               key_pulse <= cand;
               key_valid <= 1'b1;
            end
         end else begin
            case (state)
               S_IDLE: begin
                  rcnt <= '0;
               end
               S_FIRST: begin
                  if (REPEAT_EN) begin
                     if (rcnt == DELAY_LAST) begin
                        rcnt      <= '0;
                        state     <= S_REPEAT;
                        key_pulse <= key;
                        key_valid <= 1'b1;
                     end else begin
                        rcnt <= rcnt + 1'b1;
                     end
                  end else begin
                     rcnt <= '0;
                  end
               end
               S_REPEAT: begin
                  if (rcnt == RATE_LAST) begin
                     rcnt      <= '0;
                     key_pulse <= key;
                     key_valid <= 1'b1;
                  end else begin
                     rcnt <= rcnt + 1'b1;
                  end
               end
               default: begin
                  state <= S_IDLE;
                  rcnt  <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_key_pulse_gen.sv
// tb_key_pulse_gen: directed bench for key_pulse_gen with two instances,
// one without auto-repeat and one with a short repeat delay/rate.
module tb_key_pulse_gen;

   localparam logic [4:0] IDLE = 5'h1f;

   logic       clk;
   logic       rst;
   logic [4:0] key_raw;
   logic [4:0] nr_key, nr_pulse, r_key, r_pulse;
   logic       nr_valid, r_valid;

   int n_vec  = 0;
   int n_miss = 0;
   int cyc    = 0;

   int q_nr_cyc[$];
   int q_nr_code[$];
   int q_r_cyc[$];
   int q_r_code[$];

   key_pulse_gen #(
      .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b0), .REPEAT_DELAY(10),
      .REPEAT_RATE(5), .IDLE_CODE(5'h1f)
   ) u_nr (
      .clk(clk), .rst(rst), .key_raw(key_raw),
      .key(nr_key), .key_pulse(nr_pulse), .key_valid(nr_valid)
   );

   key_pulse_gen #(
      .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b1), .REPEAT_DELAY(10),
      .REPEAT_RATE(5), .IDLE_CODE(5'h1f)
   ) u_r (
      .clk(clk), .rst(rst), .key_raw(key_raw),
      .key(r_key), .key_pulse(r_pulse), .key_valid(r_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_vec(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // Record every strobe with the edge number it appeared after.
   always @(negedge clk) begin
      if (!rst) begin
         check_vec("nr_valid_map", int'(nr_valid), int'(nr_pulse != IDLE));
         check_vec("r_valid_map", int'(r_valid), int'(r_pulse != IDLE));
      end
      if (nr_valid === 1'b1) begin
         q_nr_cyc.push_back(cyc);
         q_nr_code.push_back(int'(nr_pulse));
      end
      if (r_valid === 1'b1) begin
         q_r_cyc.push_back(cyc);
         q_r_code.push_back(int'(r_pulse));
      end
   end

   task automatic clear_q();
      q_nr_cyc.delete(); q_nr_code.delete();
      q_r_cyc.delete();  q_r_code.delete();
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_pulse(input string tag, input bit rep, input int idx,
                               input int exp_cyc, input int exp_code);
      int c, k;
      c = -1; k = -1;
      if (rep) begin
         if (idx < q_r_cyc.size()) begin c = q_r_cyc[idx]; k = q_r_code[idx]; end
      end else begin
         if (idx < q_nr_cyc.size()) begin c = q_nr_cyc[idx]; k = q_nr_code[idx]; end
      end
      check_vec({tag, "_edge"}, c, exp_cyc);
      check_vec({tag, "_code"}, k, exp_code);
   endtask

   int e0, p, a, r;
   int sel, n_rep, rep_sel;

   initial begin
      rst     = 1'b0;
      key_raw = IDLE;
      #2 rst  = 1'b1;
      wait_neg(2);
      check_vec("rst_nr_key", int'(nr_key), 'h1f);
      check_vec("rst_nr_pulse", int'(nr_pulse), 'h1f);
      check_vec("rst_nr_valid", int'(nr_valid), 0);
      check_vec("rst_r_key", int'(r_key), 'h1f);
      check_vec("rst_r_state", int'(u_r.state), 0);
      rst = 1'b0;
      wait_neg(8);

      // Clean press, no repeat: 7 edges latency, one-cycle strobe.
      clear_q();
      key_raw = 5'h1e; e0 = cyc + 1;
      wait_neg(6);
      check_vec("press_key_early", int'(nr_key), 'h1f);
      check_vec("press_pulse_early", int'(nr_pulse), 'h1f);
      wait_neg(1);
      check_vec("press_key", int'(nr_key), 'h1e);
      check_vec("press_pulse", int'(nr_pulse), 'h1e);
      check_vec("press_valid", int'(nr_valid), 1);
      check_vec("press_edge", cyc, e0 + 6);
      wait_neg(1);
      check_vec("press_pulse_gone", int'(nr_pulse), 'h1f);
      check_vec("press_valid_gone", int'(nr_valid), 0);
      wait_neg(100);
      check_vec("hold_no_repeat", q_nr_cyc.size(), 1);
      check_vec("hold_state_first", int'(u_nr.state), 1);
      check_vec("hold_rcnt_zero", int'(u_nr.rcnt), 0);

      // Release: key returns to idle after 7 edges, no strobe.
      clear_q();
      key_raw = IDLE;
      wait_neg(6);
      check_vec("rel_key_early", int'(nr_key), 'h1e);
      wait_neg(1);
      check_vec("rel_key", int'(nr_key), 'h1f);
      wait_neg(5);
      check_vec("rel_no_pulse", q_nr_cyc.size(), 0);
      check_vec("rel_state_idle", int'(u_nr.state), 0);

      // Bounce 1f->1d->1f->1d with 2-cycle gaps, then stable.
      clear_q();
      key_raw = 5'h1d; wait_neg(2);
      key_raw = IDLE;  wait_neg(2);
      key_raw = 5'h1d; e0 = cyc + 1;
      wait_neg(20);
      check_vec("bounce_count", q_nr_cyc.size(), 1);
      expect_pulse("bounce", 1'b0, 0, e0 + 6, 'h1d);
      check_vec("bounce_key", int'(nr_key), 'h1d);
      key_raw = IDLE;
      wait_neg(12);

      // Auto-repeat: P, P+10, P+15, P+20, P+25, then release stops it.
      clear_q();
      key_raw = 5'h1e; p = cyc + 7;
      wait_neg(29);
      key_raw = IDLE;
      wait_neg(37);
      check_vec("rep_count", q_r_cyc.size(), 5);
      expect_pulse("rep0", 1'b1, 0, p, 'h1e);
      expect_pulse("rep1", 1'b1, 1, p + 10, 'h1e);
      expect_pulse("rep2", 1'b1, 2, p + 15, 'h1e);
      expect_pulse("rep3", 1'b1, 3, p + 20, 'h1e);
      expect_pulse("rep4", 1'b1, 4, p + 25, 'h1e);
      check_vec("rep_rel_state", int'(u_r.state), 0);

      // Code change while held re-enters the first-delay phase.
      clear_q();
      key_raw = 5'h1e; p = cyc + 7;
      wait_neg(18);
      key_raw = 5'h1c; a = cyc + 7;
      wait_neg(19);
      check_vec("chg_count", q_r_cyc.size(), 5);
      expect_pulse("chg0", 1'b1, 0, p, 'h1e);
      expect_pulse("chg1", 1'b1, 1, p + 10, 'h1e);
      expect_pulse("chg2", 1'b1, 2, p + 15, 'h1e);
      expect_pulse("chg3", 1'b1, 3, a, 'h1c);
      expect_pulse("chg4", 1'b1, 4, a + 10, 'h1c);
      expect_pulse("chg_nr", 1'b0, 1, a, 'h1c);
      key_raw = IDLE;
      wait_neg(12);

      // Asynchronous reset in the repeat phase, then a fresh press.
      key_raw = 5'h1e; p = cyc + 7;
      wait_neg(19);
      check_vec("mid_state_repeat", int'(u_r.state), 2);
      #2 rst = 1'b1;
      #1;
      check_vec("arst_key", int'(r_key), 'h1f);
      check_vec("arst_pulse", int'(r_pulse), 'h1f);
      check_vec("arst_valid", int'(r_valid), 0);
      check_vec("arst_state", int'(u_r.state), 0);
      check_vec("arst_rcnt", int'(u_r.rcnt), 0);
      wait_neg(3);
      rst = 1'b0;
      clear_q();
      r = cyc;
      wait_neg(12);
      check_vec("post_rst_count", q_r_cyc.size(), 1);
      expect_pulse("post_rst", 1'b1, 0, r + 7, 'h1e);
      expect_pulse("post_rst_nr", 1'b0, 0, r + 7, 'h1e);
      check_vec("post_rst_state", int'(u_r.state), 1);
      key_raw = IDLE;
      wait_neg(12);

      // Chain: 1e, 1e, 1d into a three-option menu selector.
      clear_q();
      key_raw = 5'h1e; wait_neg(10); key_raw = IDLE; wait_neg(10);
      key_raw = 5'h1e; wait_neg(10); key_raw = IDLE; wait_neg(10);
      key_raw = 5'h1d; wait_neg(10); key_raw = IDLE; wait_neg(10);
      check_vec("chain_count", q_nr_code.size(), 3);
      sel = 0; n_rep = 0; rep_sel = -1;
      foreach (q_nr_code[i]) begin
         if (q_nr_code[i] == 'h1e) sel = (sel + 1) % 3;
         else if (q_nr_code[i] == 'h1d) begin n_rep++; rep_sel = sel; end
      end
      check_vec("chain_reports", n_rep, 1);
      check_vec("chain_sel", rep_sel, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
